// File: rtl/sprite_rom_sched_if.sv
// Pixel scan, slot configuration and ROM address bundle for the sprite scheduler.
interface sprite_rom_sched_if #(
    parameter int ADDR_W = 12
);
    logic [8:0]        row;
    logic [9:0]        col;
    logic              pix_valid;
    logic              frame_start;
    logic              cfg_we;
    logic [1:0]        cfg_slot;
    logic              cfg_en;
    logic [9:0]        cfg_x;
    logic [8:0]        cfg_y;
    logic [ADDR_W-1:0] cfg_base;
    logic [2:0]        cfg_nframes;
    logic [5:0]        cfg_period;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [1:0]        hit_slot;

    modport master (
        output row, col, pix_valid, frame_start,
        output cfg_we, cfg_slot, cfg_en, cfg_x, cfg_y, cfg_base, cfg_nframes, cfg_period,
        input  rom_addr, rom_en, hit_slot
    );

    modport slave (
        input  row, col, pix_valid, frame_start,
        input  cfg_we, cfg_slot, cfg_en, cfg_x, cfg_y, cfg_base, cfg_nframes, cfg_period,
        output rom_addr, rom_en, hit_slot
    );
endinterface

// File: rtl/sprite_rom_sched.sv
// Four-slot animated sprite scheduler: picks the slot owning each scanned pixel
// and issues that slot's current-frame ROM address two cycles later.
module sprite_rom_sched #(
    parameter int SPR_W       = 20,
    parameter int SPR_H       = 20,
    parameter int FRAME_WORDS = 400,
    parameter int ADDR_W      = 12
) (
    input logic               clk,
    input logic               resetn,
    sprite_rom_sched_if.slave bus
);
    localparam int NS = 4;

    logic              en_q    [NS];
    logic [9:0]        x_q     [NS];
    logic [8:0]        y_q     [NS];
    logic [ADDR_W-1:0] base_q  [NS];
    logic [2:0]        nfr_q   [NS];
    logic [5:0]        per_q   [NS];
    logic [5:0]        tick_q  [NS];
    logic [5:0]        tick_d  [NS];
    logic [2:0]        frame_q [NS];
    logic [2:0]        frame_d [NS];

    // ">=" rather than "==" so an out-of-range counter still wraps to 0 on the next advance
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            tick_d[i]  = tick_q[i];
            frame_d[i] = frame_q[i];
            if (bus.cfg_we && bus.cfg_slot == 2'(i)) begin
                tick_d[i]  = 6'd0;
                frame_d[i] = 3'd0;
            end else if (bus.frame_start && en_q[i]) begin
                if (tick_q[i] >= ((per_q[i] == 6'd0) ? 6'd0 : per_q[i] - 6'd1)) begin
                    tick_d[i]  = 6'd0;
                    frame_d[i] = (frame_q[i] >= ((nfr_q[i] == 3'd0) ? 3'd0 : nfr_q[i] - 3'd1))
                                 ? 3'd0 : frame_q[i] + 3'd1;
                end else begin
                    tick_d[i] = tick_q[i] + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NS; i++) begin
                en_q[i]    <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                base_q[i]  <= '0;
                nfr_q[i]   <= 3'd1;
                per_q[i]   <= 6'd1;
                tick_q[i]  <= '0;
                frame_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                tick_q[i]  <= tick_d[i];
                frame_q[i] <= frame_d[i];
                if (bus.cfg_we && bus.cfg_slot == 2'(i)) begin
                    en_q[i]   <= bus.cfg_en;
                    x_q[i]    <= bus.cfg_x;
                    y_q[i]    <= bus.cfg_y;
                    base_q[i] <= bus.cfg_base;
                    nfr_q[i]  <= bus.cfg_nframes;
                    per_q[i]  <= bus.cfg_period;
                end
            end
        end
    end

    // Window compares carry one extra bit so origins near the screen edge never wrap
    logic [NS-1:0] hit;
    logic [1:0]    sel;
    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < NS; i++) begin
            hit[i] = en_q[i]
                  && ({1'b0, bus.row} >= {1'b0, y_q[i]})
                  && ({1'b0, bus.row} <  {1'b0, y_q[i]} + 10'(SPR_H))
                  && ({1'b0, bus.col} >= {1'b0, x_q[i]})
                  && ({1'b0, bus.col} <  {1'b0, x_q[i]} + 11'(SPR_W));
        end
        for (int i = NS - 1; i >= 0; i--) begin
            if (hit[i]) sel = 2'(i);
        end
    end

    logic              s1_valid_q;
    logic [1:0]        s1_slot_q;
    logic [8:0]        s1_rrow_q;
    logic [9:0]        s1_rcol_q;
    logic [ADDR_W-1:0] s1_base_q;
    logic [2:0]        s1_frame_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_slot_q  <= '0;
            s1_rrow_q  <= '0;
            s1_rcol_q  <= '0;
            s1_base_q  <= '0;
            s1_frame_q <= '0;
        end else begin
            s1_valid_q <= bus.pix_valid && (|hit);
            s1_slot_q  <= sel;
            s1_rrow_q  <= bus.row - y_q[sel];
            s1_rcol_q  <= bus.col - x_q[sel];
            s1_base_q  <= base_q[sel];
            s1_frame_q <= frame_q[sel];
        end
    end

    logic [ADDR_W-1:0] addr_sum;
    assign addr_sum = s1_base_q
                    + ADDR_W'(s1_frame_q) * ADDR_W'(FRAME_WORDS)
                    + ADDR_W'(s1_rrow_q) * ADDR_W'(SPR_W)
                    + ADDR_W'(s1_rcol_q);

    logic [ADDR_W-1:0] rom_addr_q;
    logic              rom_en_q;
    logic [1:0]        hit_slot_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            hit_slot_q <= '0;
        end else begin
            rom_en_q <= s1_valid_q;
            if (s1_valid_q) begin
                rom_addr_q <= addr_sum;
                hit_slot_q <= s1_slot_q;
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_en   = rom_en_q;
    assign bus.hit_slot = hit_slot_q;
endmodule

// File: tb/tb_sprite_rom_sched.sv
// Self-checking bench for sprite_rom_sched: directed vector table, corner sequences
// and random traffic against a pulse-count reference model.
module tb_sprite_rom_sched;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sprite_rom_sched_if #(.ADDR_W(12)) bus ();
    sprite_rom_sched dut (.clk(clk), .resetn(resetn), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Reference model: frame derived from the number of enabled pulses since the last write
    bit m_en [4];
    int m_x [4], m_y [4], m_base [4], m_nf [4], m_per [4], m_pul [4];
    bit pend_v, pend_en;
    int pend_addr, pend_slot, held_addr, held_slot;

    typedef struct {
        int row; int col; bit pv; bit en; int slot; int addr;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_base[i] = 0;
            m_nf[i] = 1; m_per[i] = 1; m_pul[i] = 0;
        end
        pend_v = 0; pend_en = 0; pend_addr = 0; pend_slot = 0;
        held_addr = 0; held_slot = 0;
    endfunction

    function automatic int mframe(int i);
        int p, n;
        p = (m_per[i] == 0) ? 1 : m_per[i];
        n = (m_nf[i] == 0) ? 1 : m_nf[i];
        return (m_pul[i] / p) % n;
    endfunction

    function automatic void model_pix(input int row, input int col, input bit pv,
                                      output bit en, output int addr, output int slot);
        en = 0; addr = 0; slot = 0;
        if (pv) begin
            for (int i = 3; i >= 0; i--) begin
                if (m_en[i] && row >= m_y[i] && row < m_y[i] + 20 &&
                    col >= m_x[i] && col < m_x[i] + 20) begin
                    en = 1; slot = i;
                    addr = (m_base[i] + mframe(i) * 400 + (row - m_y[i]) * 20 + (col - m_x[i])) % 4096;
                end
            end
        end
    endfunction

    task automatic drive(bit we, int slot, bit en, int x, int y, int base, int nf, int per,
                         bit fs, bit pv, int row, int col);
        bit n_en;
        int n_addr, n_slot;
        bus.cfg_we = we; bus.cfg_slot = 2'(slot); bus.cfg_en = en;
        bus.cfg_x = 10'(x); bus.cfg_y = 9'(y); bus.cfg_base = 12'(base);
        bus.cfg_nframes = 3'(nf); bus.cfg_period = 6'(per);
        bus.frame_start = fs; bus.pix_valid = pv; bus.row = 9'(row); bus.col = 10'(col);
        model_pix(row, col, pv, n_en, n_addr, n_slot);
        for (int i = 0; i < 4; i++) begin
            if (we && slot == i) begin
                m_en[i] = en; m_x[i] = x; m_y[i] = y; m_base[i] = base;
                m_nf[i] = nf; m_per[i] = per; m_pul[i] = 0;
            end else if (fs && m_en[i]) begin
                m_pul[i]++;
            end
        end
        @(posedge clk);
        #1;
        if (pend_v && pend_en) begin
            held_addr = pend_addr; held_slot = pend_slot;
        end
        chk("model_en", int'(bus.rom_en), (pend_v && pend_en) ? 1 : 0);
        chk("model_addr", int'(bus.rom_addr), held_addr);
        chk("model_slot", int'(bus.hit_slot), held_slot);
        pend_v = 1; pend_en = n_en; pend_addr = n_addr; pend_slot = n_slot;
    endtask

    task automatic pix(int row, int col, bit pv);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, pv, row, col);
    endtask

    task automatic cfg(int slot, bit en, int x, int y, int base, int nf, int per);
        drive(1, slot, en, x, y, base, nf, per, 0, 0, 0, 0);
    endtask

    task automatic pulse();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic probe(string name, int row, int col, int exp_addr, int exp_slot);
        pix(row, col, 1);
        pix(0, 0, 0);
        chk({name, "_en"}, int'(bus.rom_en), 1);
        chk({name, "_addr"}, int'(bus.rom_addr), exp_addr);
        chk({name, "_slot"}, int'(bus.hit_slot), exp_slot);
    endtask

    task automatic probe_miss(string name, int row, int col);
        pix(row, col, 1);
        pix(0, 0, 0);
        chk({name, "_en"}, int'(bus.rom_en), 0);
    endtask

    initial begin
        tbl[0]  = '{85, 95, 1, 1, 0, 105};
        tbl[1]  = '{79, 95, 1, 1, 2, 2027};
        tbl[2]  = '{77, 95, 1, 0, 2, 2027};
        tbl[3]  = '{80, 90, 1, 1, 0, 0};
        tbl[4]  = '{99, 109, 1, 1, 0, 399};
        tbl[5]  = '{100, 95, 1, 0, 0, 399};
        tbl[6]  = '{85, 110, 1, 0, 0, 399};
        tbl[7]  = '{85, 95, 0, 0, 0, 399};
        tbl[8]  = '{97, 107, 1, 1, 0, 357};
        tbl[9]  = '{98, 88, 1, 0, 0, 357};
        tbl[10] = '{78, 88, 1, 1, 2, 2000};

        bus.cfg_we = 0; bus.cfg_slot = 0; bus.cfg_en = 0; bus.cfg_x = 0; bus.cfg_y = 0;
        bus.cfg_base = 0; bus.cfg_nframes = 0; bus.cfg_period = 0;
        bus.frame_start = 0; bus.pix_valid = 0; bus.row = 0; bus.col = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_en", int'(bus.rom_en), 0);
        chk("reset_addr", int'(bus.rom_addr), 0);
        chk("reset_slot", int'(bus.hit_slot), 0);
        resetn = 1;

        // Directed vectors: slot0 and an overlapping slot2
        cfg(0, 1, 90, 80, 0, 4, 1);
        cfg(2, 1, 88, 78, 2000, 1, 1);
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) pix(tbl[i].row, tbl[i].col, tbl[i].pv);
            else pix(0, 0, 0);
            if (i > 0) begin
                chk("vec_en", int'(bus.rom_en), int'(tbl[i-1].en));
                chk("vec_addr", int'(bus.rom_addr), tbl[i-1].addr);
                chk("vec_slot", int'(bus.hit_slot), tbl[i-1].slot);
            end
        end

        cfg(0, 0, 90, 80, 0, 4, 1);
        probe("prio_slot2", 85, 95, 2147, 2);

        cfg(0, 1, 90, 80, 0, 4, 1);
        probe("anim0", 80, 90, 0, 0);
        for (int p = 1; p <= 5; p++) begin
            pulse();
            probe("anim", 80, 90, (p % 4) * 400, 0);
        end

        cfg(1, 1, 10, 10, 1600, 3, 3);
        for (int p = 1; p <= 9; p++) begin
            pulse();
            if (p % 3 == 0) probe("period", 10, 10, 1600 + ((p / 3) % 3) * 400, 1);
        end

        cfg(0, 1, 90, 80, 0, 4, 2);
        cfg(1, 1, 10, 10, 1600, 7, 1);
        repeat (5) pulse();
        probe("coll_pre", 80, 90, 800, 0);
        drive(1, 0, 1, 90, 80, 0, 4, 2, 1, 0, 0, 0);
        probe("coll_s0", 80, 90, 0, 0);
        probe("coll_s1", 10, 10, 4000, 1);
        pulse();
        probe("coll_tick", 80, 90, 0, 0);
        probe("coll_s1w", 10, 10, 1600, 1);

        cfg(3, 1, 1010, 0, 0, 0, 0);
        probe_miss("edge_col", 5, 2);
        probe("edge_hit", 5, 1015, 105, 3);
        repeat (3) pulse();
        probe("edge_nf0", 5, 1015, 105, 3);
        cfg(2, 1, 300, 500, 0, 2, 1);
        probe_miss("edge_row", 3, 305);

        // Asynchronous reset with a hit in flight
        pix(85, 95, 1);
        #3;
        resetn = 0;
        #1;
        chk("midrst_en", int'(bus.rom_en), 0);
        chk("midrst_addr", int'(bus.rom_addr), 0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1;
        drive(1, 0, 1, 90, 80, 0, 4, 1, 0, 1, 80, 90);
        pix(80, 90, 1);
        chk("postrst_c1", int'(bus.rom_en), 0);
        pix(0, 0, 0);
        chk("postrst_c2", int'(bus.rom_en), 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit we, fs, pv;
            int s, row, col;
            we = ($urandom_range(0, 99) < 3);
            fs = ($urandom_range(0, 99) < 6);
            pv = ($urandom_range(0, 99) < 90);
            s  = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 70) begin
                row = (m_y[s] + $urandom_range(0, 21) + 511) % 512;
                col = (m_x[s] + $urandom_range(0, 21) + 1023) % 1024;
            end else begin
                row = $urandom_range(0, 511);
                col = $urandom_range(0, 1023);
            end
            drive(we, $urandom_range(0, 3), ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 4095),
                  $urandom_range(0, 7), $urandom_range(0, 5), fs, pv, row, col);
        end
        pix(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
